// File: rtl/md_sched.sv
// md_sched: HI/LO sequencer between the E stage and the multiply/divide core.
// Optional MD_FWD_EN: forward core_hi/core_lo to mfhi/mflo in the done cycle.
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        core_start,
  output logic [1:0]  core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_hi,
  input  logic [31:0] core_lo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        start_q, start_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_md;
  logic        is_mt;
  logic        is_mf;
  logic        is_hl;
  logic        is_div;
  logic        sel_hi;
  logic [1:0]  dec_op;
  logic        accept;
  logic        done_ok;
  logic        fwd;

  always_comb begin
    is_md  = 1'b0;
    is_mt  = 1'b0;
    is_mf  = 1'b0;
    is_div = 1'b0;
    sel_hi = 1'b0;
    dec_op = 2'b00;
    case (e_op)
      4'd1: begin is_md = 1'b1; dec_op = 2'b00; end
      4'd2: begin is_md = 1'b1; dec_op = 2'b01; end
      4'd3: begin
        is_md  = 1'b1;
        is_div = 1'b1;
        dec_op = 2'b10;
      end
      4'd4: begin
        is_md  = 1'b1;
        is_div = 1'b1;
        dec_op = 2'b11;
      end
      4'd5: begin is_mt = 1'b1; sel_hi = 1'b1; end
      4'd6: begin is_mt = 1'b1; end
      4'd7: begin is_mf = 1'b1; sel_hi = 1'b1; end
      4'd8: begin is_mf = 1'b1; end
      default: ;
    endcase
    is_hl = is_md | is_mt | is_mf;
  end

  // the launch cycle never completes; done there is a leftover
  assign done_ok = (state_q == BUSY) & core_done & ~start_q;

`ifdef MD_FWD_EN
  assign fwd = done_ok;
`else
  assign fwd = 1'b0;
`endif

  assign accept = (state_q == IDLE) & ~flush & is_hl;
  assign stall  = busy_q & is_hl & ~flush & ~(is_mf & fwd);

  always_comb begin
    rd_data = 32'h0;
    if (is_mf) begin
      if (fwd) begin
        rd_data = sel_hi ? core_hi : core_lo;
      end else begin
        rd_data = sel_hi ? hi_q : lo_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // divide by zero is retired silently with HI/LO untouched
          if (is_md && !(is_div && e_b == 32'h0)) begin
            a_d     = e_a;
            b_d     = e_b;
            op_d    = dec_op;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = BUSY;
          end
          if (is_mt && sel_hi) hi_d = e_a;
          if (is_mt && !sel_hi) lo_d = e_a;
        end
      end
      BUSY: begin
        if (done_ok) begin
          hi_d    = core_hi;
          lo_d    = core_lo;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign core_start = start_q;
  assign core_op    = op_q;
  assign core_a     = a_q;
  assign core_b     = b_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: random E-stage traffic against an operation-level model
// of md_sched, with a bench-side core that computes real mult/div results.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic        flush;
  logic        stall;
  logic [31:0] rd_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        core_start;
  logic [1:0]  core_op;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_hi;
  logic [31:0] core_lo;

  md_sched dut (
    .clk        (clk),
    .reset      (reset),
    .e_op       (e_op),
    .e_a        (e_a),
    .e_b        (e_b),
    .flush      (flush),
    .stall      (stall),
    .rd_data    (rd_data),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .core_start (core_start),
    .core_op    (core_op),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_done  (core_done),
    .core_hi    (core_hi),
    .core_lo    (core_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  int cyc;

  // model of the architectural view
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [1:0]  m_op;
  logic        m_busy;
  logic        m_start;
  logic [63:0] m_res;

  // bench core scheduling
  logic pend;
  int   done_cyc;
  logic stale;
  int   stale_cyc;
  int   next_lat;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] md_res(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic step(input logic r, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic fl);
    logic d, hl, mf, fwd, es;
    logic [31:0] ch, cl, er;
    int lat;
    d  = 1'b0;
    ch = $urandom;
    cl = $urandom;
    if (pend && cyc == done_cyc) begin
      d    = 1'b1;
      ch   = m_res[63:32];
      cl   = m_res[31:0];
      pend = 1'b0;
    end else if (stale && cyc == stale_cyc) begin
      stale = 1'b0;
      if (!m_busy) d = 1'b1;
    end else if ((!m_busy || m_start) && $urandom_range(0, 5) == 0) begin
      d = 1'b1;
    end
    reset     = r;
    e_op      = op;
    e_a       = a;
    e_b       = b;
    flush     = fl;
    core_done = d;
    core_hi   = ch;
    core_lo   = cl;
    #1;
    hl  = (op >= 4'd1) && (op <= 4'd8);
    mf  = (op == 4'd7) || (op == 4'd8);
    fwd = 1'b0;
`ifdef MD_FWD_EN
    fwd = m_busy && d && !m_start;
`endif
    es = m_busy && hl && !fl && !(mf && fwd);
    if (!mf) er = 32'h0;
    else if (fwd) er = (op == 4'd7) ? ch : cl;
    else er = (op == 4'd7) ? m_hi : m_lo;
    chk("stall", 32'(stall), 32'(es));
    chk("rd_data", rd_data, er);
    @(posedge clk);
    if (!r) begin
      if (pend) begin
        stale     = 1'b1;
        stale_cyc = done_cyc;
        pend      = 1'b0;
      end
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
      m_op = 0; m_busy = 0; m_start = 0;
    end else if (m_busy) begin
      if (d && !m_start) begin
        m_hi   = ch;
        m_lo   = cl;
        m_busy = 1'b0;
      end
      m_start = 1'b0;
    end else if (!fl && hl) begin
      if (op <= 4'd4) begin
        if (!(op >= 4'd3 && b == 32'h0)) begin
          m_busy   = 1'b1;
          m_start  = 1'b1;
          m_op     = 2'(op - 4'd1);
          m_a      = a;
          m_b      = b;
          m_res    = md_res(m_op, a, b);
          lat      = (next_lat != 0) ? next_lat : $urandom_range(1, 4);
          pend     = 1'b1;
          done_cyc = cyc + 1 + lat;
        end
      end else if (op == 4'd5) begin
        m_hi = a;
      end else if (op == 4'd6) begin
        m_lo = a;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("core_start", 32'(core_start), 32'(m_start));
    chk("core_op", 32'(core_op), 32'(m_op));
    chk("core_a", core_a, m_a);
    chk("core_b", core_b, m_b);
    cyc++;
    @(negedge clk);
  endtask

  logic [63:0] exp_mu;

  initial begin
    errors = 0; checks = 0; cyc = 0;
    m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
    m_op = 0; m_busy = 0; m_start = 0; m_res = 0;
    pend = 0; done_cyc = 0; stale = 0; stale_cyc = 0; next_lat = 0;
    reset = 1'b0; e_op = 0; e_a = 0; e_b = 0; flush = 0;
    core_done = 0; core_hi = 0; core_lo = 0;
    @(negedge clk);

    repeat (3) step(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                    1'($urandom_range(0, 1)));
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    next_lat = 4;
    step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_start", 32'(core_start), 32'h1);
    chk("mult_op", 32'(core_op), 32'h0);
    step(1'b1, 4'd7, 32'h0, 32'h0, 1'b0);
    chk("mult_start_pulse", 32'(core_start), 32'h0);
    repeat (4) step(1'b1, 4'd7, 32'h0, 32'h0, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    step(1'b1, 4'd7, 32'h0, 32'h0, 1'b0);

    step(1'b1, 4'd3, 32'd7, 32'h0, 1'b0);
    chk("dz_busy", 32'(busy), 32'h0);
    chk("dz_start", 32'(core_start), 32'h0);
    step(1'b1, 4'd8, 32'h0, 32'h0, 1'b0);
    chk("dz_lo", lo, 32'hFFFFFFFA);

    next_lat = 3;
    exp_mu = md_res(2'd1, 32'hC0000001, 32'h00000011);
    step(1'b1, 4'd2, 32'hC0000001, 32'h00000011, 1'b0);
    step(1'b1, 4'd5, 32'h00001234, 32'h0, 1'b1);
    repeat (4) step(1'b1, 4'd0, 32'h0, 32'h0, 1'b0);
    chk("multu_hi", hi, exp_mu[63:32]);
    chk("multu_lo", lo, exp_mu[31:0]);

    step(1'b1, 4'd6, 32'hDEADBEEF, 32'h0, 1'b0);
    step(1'b1, 4'd8, 32'h0, 32'h0, 1'b0);
    chk("mtlo_lo", lo, 32'hDEADBEEF);

    step(1'b1, 4'd1, 32'd5, 32'd7, 1'b0);
    step(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    repeat (4) step(1'b1, 4'd0, 32'h0, 32'h0, 1'b0);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    next_lat = 0;

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 49) != 0),
           4'($urandom_range(0, 15)),
           $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
           1'($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
